// File: rtl/ball_frame_control.sv
// ball_frame_control
//   Frame sequencer for the pong ball pipeline. It steps the render stage
//   through black-screen / clear-old / draw-new phases, gates the physics
//   stage, keeps the score, and counts frame strobes that arrive while a
//   phase is still in progress.
//
// Ports
//   clk                 single clock, rising edge
//   resetn              asynchronous active-low reset
//   frameTick           one-cycle strobe per displayed frame
//   start               new-game request level (debounced key)
//   lhs_scored          left-side goal level, may stay high several cycles
//   rhs_scored          right-side goal level, may stay high several cycles
//   done_clearOld       render stage finished clearing the old ball
//   done_drawNew        render stage finished drawing the new ball
//   done_blackScreen    render stage finished blanking the screen
//   clearOld_pulse      high for the whole clear phase
//   drawNew_pulse       high for the whole draw phase
//   blackScreen_pulse   high for the whole black-screen phase
//   move_enable         physics/movement enable, high while idle
//   lhs_score           left points, saturating at WIN_SCORE
//   rhs_score           right points, saturating at WIN_SCORE
//   game_over           high while a game has been won
//   frame_overruns      saturating count of dropped frameTicks
module ball_frame_control #(
  parameter int FRAME_RATE = 15,
  parameter int WIN_SCORE  = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frameTick,
  input  logic       start,
  input  logic       lhs_scored,
  input  logic       rhs_scored,
  input  logic       done_clearOld,
  input  logic       done_drawNew,
  input  logic       done_blackScreen,
  output logic       clearOld_pulse,
  output logic       drawNew_pulse,
  output logic       blackScreen_pulse,
  output logic       move_enable,
  output logic [3:0] lhs_score,
  output logic [3:0] rhs_score,
  output logic       game_over,
  output logic [7:0] frame_overruns
);

  // Reject parameter values the fixed-width counters cannot represent.
  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win_score
    $error("WIN_SCORE must be in 1..15");
  end
  if (FRAME_RATE < 1 || FRAME_RATE > 255) begin : g_bad_frame_rate
    $error("FRAME_RATE must be in 1..255");
  end

  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_BLACK,
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_OVER
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_lhs_d;
  logic        r_rhs_d;
  logic        r_start_d;
  logic        r_goal_pending;
  logic [3:0]  r_lhs_score;
  logic [3:0]  r_rhs_score;
  logic [7:0]  r_overruns;
  logic        r_clear;
  logic        r_draw;
  logic        r_black;
  logic        r_move;
  logic        r_over;

  logic        w_score_ok;
  logic        w_lhs_goal;
  logic        w_rhs_goal;
  logic        w_start_rise;
  logic        w_pending;
  logic        w_drop;
  logic [3:0]  w_lhs_nxt;
  logic [3:0]  w_rhs_nxt;

  // Goals only count while the ball is in play; edges seen during the
  // black screen or after the game is won are discarded.
  assign w_score_ok   = (r_state == S_IDLE) || (r_state == S_CLEAR) ||
                        (r_state == S_DRAW);
  assign w_lhs_goal   = lhs_scored & ~r_lhs_d & w_score_ok;
  assign w_rhs_goal   = rhs_scored & ~r_rhs_d & w_score_ok;
  assign w_start_rise = start & ~r_start_d;
  // A goal seen this very cycle already counts as pending, so it beats a
  // simultaneous frameTick in S_IDLE.
  assign w_pending    = r_goal_pending | w_lhs_goal | w_rhs_goal;
  assign w_drop       = frameTick && ((r_state == S_BLACK) ||
                        (r_state == S_CLEAR) || (r_state == S_DRAW));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_BLACK;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BLACK: begin
        if (done_blackScreen) begin
          if (r_lhs_score == WIN || r_rhs_score == WIN) w_next = S_OVER;
          else                                          w_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (w_pending)      w_next = S_BLACK;
        else if (frameTick) w_next = S_CLEAR;
      end
      S_CLEAR: if (done_clearOld)  w_next = S_DRAW;
      S_DRAW:  if (done_drawNew)   w_next = S_IDLE;
      S_OVER:  if (w_start_rise)   w_next = S_BLACK;
      default: w_next = S_BLACK;
    endcase
  end

  always_comb begin
    w_lhs_nxt = r_lhs_score;
    w_rhs_nxt = r_rhs_score;
    if (r_state == S_OVER && w_start_rise) begin
      w_lhs_nxt = 4'd0;
      w_rhs_nxt = 4'd0;
    end else begin
      if (w_lhs_goal && r_lhs_score != WIN) w_lhs_nxt = r_lhs_score + 4'd1;
      if (w_rhs_goal && r_rhs_score != WIN) w_rhs_nxt = r_rhs_score + 4'd1;
    end
  end

  // Outputs are registered from the next state so each phase level rises
  // on the same edge the state enters that phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lhs_d        <= 1'b0;
      r_rhs_d        <= 1'b0;
      r_start_d      <= 1'b0;
      r_goal_pending <= 1'b0;
      r_lhs_score    <= 4'd0;
      r_rhs_score    <= 4'd0;
      r_overruns     <= 8'd0;
      r_clear        <= 1'b0;
      r_draw         <= 1'b0;
      r_black        <= 1'b1;
      r_move         <= 1'b0;
      r_over         <= 1'b0;
    end else begin
      r_lhs_d        <= lhs_scored;
      r_rhs_d        <= rhs_scored;
      r_start_d      <= start;
      r_goal_pending <= (w_next == S_BLACK) ? 1'b0 : w_pending;
      r_lhs_score    <= w_lhs_nxt;
      r_rhs_score    <= w_rhs_nxt;
      if (w_drop && r_overruns != 8'hFF) r_overruns <= r_overruns + 8'd1;
      r_clear        <= (w_next == S_CLEAR);
      r_draw         <= (w_next == S_DRAW);
      r_black        <= (w_next == S_BLACK);
      r_move         <= (w_next == S_IDLE);
      r_over         <= (w_next == S_OVER);
    end
  end

  assign clearOld_pulse    = r_clear;
  assign drawNew_pulse     = r_draw;
  assign blackScreen_pulse = r_black;
  assign move_enable       = r_move;
  assign lhs_score         = r_lhs_score;
  assign rhs_score         = r_rhs_score;
  assign game_over         = r_over;
  assign frame_overruns    = r_overruns;

endmodule

// File: tb/tb_ball_frame_control.sv
module tb_ball_frame_control;

  localparam int WIN = 7;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       frameTick, start, lhs_scored, rhs_scored;
  logic       done_clearOld, done_drawNew, done_blackScreen;
  logic       clearOld_pulse, drawNew_pulse, blackScreen_pulse, move_enable;
  logic [3:0] lhs_score, rhs_score;
  logic       game_over;
  logic [7:0] frame_overruns;

  ball_frame_control #(.FRAME_RATE(15), .WIN_SCORE(WIN)) dut (
    .clk(clk), .resetn(resetn), .frameTick(frameTick), .start(start),
    .lhs_scored(lhs_scored), .rhs_scored(rhs_scored),
    .done_clearOld(done_clearOld), .done_drawNew(done_drawNew),
    .done_blackScreen(done_blackScreen),
    .clearOld_pulse(clearOld_pulse), .drawNew_pulse(drawNew_pulse),
    .blackScreen_pulse(blackScreen_pulse), .move_enable(move_enable),
    .lhs_score(lhs_score), .rhs_score(rhs_score), .game_over(game_over),
    .frame_overruns(frame_overruns)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model of the sequencer, advanced once per clock.
  typedef enum int {MB, MI, MC, MD, MO} mst_t;
  mst_t m_st;
  int   m_l, m_r, m_ovr;
  bit   m_pend, m_ld, m_rd, m_sd;

  logic [31:0] sb[$];
  logic [31:0] w_dut;
  assign w_dut = {11'd0, clearOld_pulse, drawNew_pulse, blackScreen_pulse,
                  move_enable, lhs_score, rhs_score, game_over, frame_overruns};

  function automatic logic [31:0] exp_vec();
    return {11'd0, m_st == MC, m_st == MD, m_st == MB, m_st == MI,
            4'(m_l), 4'(m_r), m_st == MO, 8'(m_ovr)};
  endfunction

  function automatic void model_reset();
    m_st = MB; m_l = 0; m_r = 0; m_ovr = 0;
    m_pend = 0; m_ld = 0; m_rd = 0; m_sd = 0;
  endfunction

  function automatic void model_clk();
    bit   lr, rr, sr, inplay, goal;
    mst_t nxt;
    inplay = (m_st == MI) || (m_st == MC) || (m_st == MD);
    lr = inplay && lhs_scored && !m_ld;
    rr = inplay && rhs_scored && !m_rd;
    sr = start && !m_sd;
    goal = lr || rr;
    nxt = m_st;
    case (m_st)
      MB: if (done_blackScreen) nxt = (m_l == WIN || m_r == WIN) ? MO : MI;
      MI: if (m_pend || goal) nxt = MB; else if (frameTick) nxt = MC;
      MC: if (done_clearOld) nxt = MD;
      MD: if (done_drawNew) nxt = MI;
      MO: if (sr) nxt = MB;
      default: nxt = MB;
    endcase
    if (frameTick && (m_st == MB || m_st == MC || m_st == MD) && m_ovr < 255) m_ovr++;
    if (lr && m_l < WIN) m_l++;
    if (rr && m_r < WIN) m_r++;
    if (m_st == MO && sr) begin m_l = 0; m_r = 0; end
    m_pend = (nxt == MB) ? 1'b0 : (m_pend || goal);
    m_ld = lhs_scored; m_rd = rhs_scored; m_sd = start;
    m_st = nxt;
  endfunction

  // Push the expected post-edge outputs, clock once, then compare.
  task automatic step();
    logic [31:0] e;
    if (resetn) model_clk(); else model_reset();
    sb.push_back(exp_vec());
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("cycle", w_dut, e);
    end
  endtask

  initial begin
    frameTick = 0; start = 0; lhs_scored = 0; rhs_scored = 0;
    done_clearOld = 0; done_drawNew = 0; done_blackScreen = 0;

    #2 resetn = 0;
    model_reset();
    #1 chk("rst_vec", w_dut, exp_vec());
    chk("rst_black", {31'd0, blackScreen_pulse}, 32'd1);
    step(); step();
    resetn = 1;

    // Power-up frame sequence
    step(); step();
    chk("hold_black", {31'd0, blackScreen_pulse}, 32'd1);
    done_blackScreen = 1; step(); done_blackScreen = 0;
    chk("idle_move", {31'd0, move_enable}, 32'd1);
    repeat (4) step();
    frameTick = 1; step(); frameTick = 0;
    chk("clr_lat", {31'd0, clearOld_pulse}, 32'd1);
    repeat (2) step();
    done_clearOld = 1; step(); done_clearOld = 0;
    chk("draw_lat", {31'd0, drawNew_pulse}, 32'd1);
    repeat (2) step();
    done_drawNew = 1; step(); done_drawNew = 0;
    chk("move_back", {31'd0, move_enable}, 32'd1);

    // Three dropped ticks during one clear phase
    frameTick = 1; step(); frameTick = 0; step();
    repeat (3) begin frameTick = 1; step(); frameTick = 0; step(); end
    chk("ovr3", {24'd0, frame_overruns}, 32'd3);
    done_clearOld = 1; step(); done_clearOld = 0;
    done_drawNew = 1; step(); done_drawNew = 0;

    // Goal level held for six cycles during the draw phase
    frameTick = 1; step(); frameTick = 0;
    done_clearOld = 1; step(); done_clearOld = 0;
    lhs_scored = 1; repeat (6) step(); lhs_scored = 0;
    chk("lhs_once", {28'd0, lhs_score}, 32'd1);
    done_drawNew = 1; step(); done_drawNew = 0;
    step();
    chk("goal_black", {31'd0, blackScreen_pulse}, 32'd1);

    // Mismatched done strobes and start are ignored in S_BLACK
    done_clearOld = 1; done_drawNew = 1; start = 1; step();
    done_clearOld = 0; done_drawNew = 0; start = 0;
    chk("stray", {31'd0, blackScreen_pulse}, 32'd1);
    done_blackScreen = 1; step(); done_blackScreen = 0;
    start = 1; step(); start = 0;
    chk("start_ign", {31'd0, move_enable}, 32'd1);
    done_clearOld = 1; step(); done_clearOld = 0;

    // Build to 6/6; the first goal coincides with a frameTick
    for (int i = 0; i < 5; i++) begin
      lhs_scored = 1; rhs_scored = 1; frameTick = (i == 0);
      step();
      lhs_scored = 0; rhs_scored = 0; frameTick = 0;
      step();
      done_blackScreen = 1; step(); done_blackScreen = 0;
    end
    rhs_scored = 1; step(); rhs_scored = 0; step();
    done_blackScreen = 1; step(); done_blackScreen = 0;
    chk("six_six", {24'd0, lhs_score, rhs_score}, 32'h66);

    // Simultaneous winning goals
    lhs_scored = 1; rhs_scored = 1; step();
    chk("seven_seven", {24'd0, lhs_score, rhs_score}, 32'h77);
    lhs_scored = 0; rhs_scored = 0; step();
    done_blackScreen = 1; step(); done_blackScreen = 0;
    chk("game_over", {31'd0, game_over}, 32'd1);
    lhs_scored = 1; step(); lhs_scored = 0; step();
    chk("over_hold", {28'd0, lhs_score}, 32'd7);

    // New game
    start = 1; step();
    chk("restart", {23'd0, lhs_score, rhs_score, game_over}, 32'd0);
    chk("restart_blk", {31'd0, blackScreen_pulse}, 32'd1);
    step(); start = 0;

    // Saturation of the overrun counter
    frameTick = 1; repeat (300) step(); frameTick = 0;
    chk("ovr_sat", {24'd0, frame_overruns}, 32'd255);

    // Asynchronous reset in the middle of a draw phase
    done_blackScreen = 1; step(); done_blackScreen = 0;
    frameTick = 1; step(); frameTick = 0;
    done_clearOld = 1; step(); done_clearOld = 0;
    lhs_scored = 1; step(); lhs_scored = 0; step();
    chk("pre_arst", {28'd0, lhs_score}, 32'd1);
    #3 resetn = 0;
    model_reset();
    #1 chk("arst_vec", w_dut, exp_vec());
    chk("arst_draw", {31'd0, drawNew_pulse}, 32'd0);
    step();
    resetn = 1;
    step(); step();
    chk("post_arst", {31'd0, blackScreen_pulse}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
